// File: rtl/ls192_cmd_sequencer.sv
// ls192_cmd_sequencer: command-driven pin sequencer for one 74LS192 up/down
// decade counter. Takes clear/load/up-N/down-N commands over valid/ready,
// produces cpu/cpd/pl_n/mr waveforms with programmable widths, and tracks a
// shadow of the counter value plus the number of decade wraps.
// Optional build macro: LS192_READBACK_CHECK_EN adds o_mismatch, which compares
// the real counter outputs (i_q) against the shadow as each command retires.
module ls192_cmd_sequencer #(
  parameter int PW_LOW  = 2,
  parameter int PW_HIGH = 2,
  parameter int PW_CTRL = 2,
  parameter int SETTLE  = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [3:0] i_cmd_data,
  input  logic [7:0] i_cmd_cnt,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_shadow,
  output logic [7:0] o_wraps,
  output logic       o_cpu,
  output logic       o_cpd,
  output logic       o_pl_n,
  output logic       o_mr,
  output logic [3:0] o_p,
  input  logic [3:0] i_q
`ifdef LS192_READBACK_CHECK_EN
  ,
  output logic       o_mismatch
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_PLO, S_PHI, S_SETTLE, S_DONE
  } state_t;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;

  // Timer reload values are duration-1: the timer expires on the phase's last cycle.
  localparam logic [15:0] TMR_CTRL    = 16'(PW_CTRL - 1);
  localparam logic [15:0] TMR_LOW     = 16'(PW_LOW - 1);
  localparam logic [15:0] TMR_HIGH    = 16'(PW_HIGH - 1);
  localparam logic [15:0] TMR_SETTLE  = 16'(SETTLE - 1);
  // A zero-count command has no pin edge to settle from; it gets one extra
  // settle cycle so its done lands one cycle later than SETTLE+1.
  localparam logic [15:0] TMR_SETTLE0 = 16'(SETTLE);

  state_t      r_state, w_next;
  logic [15:0] r_tmr;
  logic [7:0]  r_left, r_wraps;
  logic [3:0]  r_shadow, r_p;
  logic        r_up;
  logic        w_accept, w_tmr_zero, w_enter;
  logic [3:0]  w_step;
  logic        w_wrap;

  assign w_accept   = i_cmd_valid && (r_state == S_IDLE);
  assign w_tmr_zero = (r_tmr == 16'd0);
  assign w_enter    = (w_next != r_state);

  // Shadow value after one counting edge in the latched direction
  always_comb begin
    w_step = 4'd0;
    w_wrap = 1'b0;
    if (r_up) begin
      if (r_shadow == 4'd9)     w_wrap = 1'b1;
      else if (r_shadow < 4'd9) w_step = r_shadow + 4'd1;
    end else begin
      if (r_shadow == 4'd0) begin
        w_step = 4'd9;
        w_wrap = 1'b1;
      end else begin
        w_step = r_shadow - 4'd1;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (i_cmd_op)
            OP_CLR:  w_next = S_CLR;
            OP_LOAD: w_next = S_LOAD;
            default: w_next = (i_cmd_cnt != 8'd0) ? S_PLO : S_SETTLE;
          endcase
        end
      end
      S_CLR, S_LOAD: if (w_tmr_zero) w_next = S_SETTLE;
      S_PLO:         if (w_tmr_zero) w_next = S_PHI;
      S_PHI:         if (w_tmr_zero) w_next = (r_left != 8'd0) ? S_PLO : S_SETTLE;
      S_SETTLE:      if (w_tmr_zero) w_next = S_DONE;
      S_DONE:        w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  // Phase timer: reloaded on every state change, then counts down to zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmr <= 16'd0;
    end else if (w_enter) begin
      case (w_next)
        S_CLR, S_LOAD: r_tmr <= TMR_CTRL;
        S_PLO:         r_tmr <= TMR_LOW;
        S_PHI:         r_tmr <= TMR_HIGH;
        S_SETTLE:      r_tmr <= (r_state == S_IDLE) ? TMR_SETTLE0 : TMR_SETTLE;
        default:       r_tmr <= 16'd0;
      endcase
    end else if (!w_tmr_zero) begin
      r_tmr <= r_tmr - 16'd1;
    end
  end

  // Command latch, shadow and wrap tracking (counting edge = entry into PHI)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= 4'd0;
      r_wraps  <= 8'd0;
      r_left   <= 8'd0;
      r_up     <= 1'b0;
      r_p      <= 4'd0;
    end else begin
      if (w_accept) begin
        r_wraps <= 8'd0;
        r_left  <= i_cmd_cnt;
        r_up    <= (i_cmd_op == OP_UP);
        if (i_cmd_op == OP_LOAD) begin
          r_p      <= i_cmd_data;
          r_shadow <= i_cmd_data;
        end else if (i_cmd_op == OP_CLR) begin
          r_shadow <= 4'd0;
        end
      end
      if (w_enter && (w_next == S_PHI)) begin
        r_shadow <= w_step;
        r_left   <= r_left - 8'd1;
        if (w_wrap && (r_wraps != 8'hFF)) r_wraps <= r_wraps + 8'd1;
      end
    end
  end

  // Pin and handshake decode from the current state
  always_comb begin
    o_cpu       = 1'b1;
    o_cpd       = 1'b1;
    o_pl_n      = 1'b1;
    o_mr        = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_cmd_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy      = 1'b0;
        o_cmd_ready = 1'b1;
      end
      S_CLR:  o_mr   = 1'b1;
      S_LOAD: o_pl_n = 1'b0;
      S_PLO: begin
        if (r_up) o_cpu = 1'b0;
        else      o_cpd = 1'b0;
      end
      S_DONE: begin
        o_busy = 1'b0;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_shadow = r_shadow;
  assign o_wraps  = r_wraps;
  assign o_p      = r_p;

`ifdef LS192_READBACK_CHECK_EN
  logic r_mismatch;

  // Compare the real counter with the shadow as the command retires
  always_ff @(posedge i_clk) begin
    if (i_rst)                  r_mismatch <= 1'b0;
    else if (r_state == S_DONE) r_mismatch <= (i_q != r_shadow);
  end

  assign o_mismatch = r_mismatch;
`else
  logic w_unused_q;
  assign w_unused_q = ^i_q;
`endif

endmodule
